// File: rtl/ext_entry_queue.sv
// Request/response front end for an external entry method: a DEPTH-entry call FIFO
// feeding a small FSM that forms each result (concatenation or wrapping sum) and holds it until taken.
module ext_entry_queue #(
    parameter int ARG_W    = 32,
    parameter int NUM_ARGS = 2,
    parameter int DEPTH    = 4,
    parameter int MODE     = 0,
    localparam int RES_W   = ARG_W * NUM_ARGS,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_req_valid,
    output logic             f_req_ready,
    output logic             f_req_busy,
    input  logic [RES_W-1:0] f_req_args,
    output logic [CW-1:0]    f_req_count,
    output logic             f_res_valid,
    input  logic             f_res_ready,
    output logic [RES_W-1:0] f_res_0,
    output logic [1:0]       dbg_state
);

    // Handshakes: a call moves on a rising edge with f_req_valid & f_req_ready;
    // a result moves on a rising edge with f_res_valid & f_res_ready. Ready never looks at valid.

    localparam int AW = $clog2(DEPTH);
    localparam int KW = (NUM_ARGS > 1) ? $clog2(NUM_ARGS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [RES_W-1:0] work_q, work_d;
    logic [ARG_W-1:0] acc_q, acc_d;
    logic [KW-1:0]    k_q, k_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             res_valid_q, res_valid_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [RES_W-1:0] mem_q [DEPTH];
    logic             push;
    logic             pop;

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        acc_d       = acc_q;
        k_d         = k_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    work_d  = mem_q[rd_ptr_q];
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (MODE == 0) begin
                    res_d       = work_q;
                    res_valid_d = 1'b1;
                    state_d     = S_OUT;
                end else begin
                    // The working copy shifts left so the next argument is always the top slice.
                    acc_d  = acc_q + work_q[RES_W-1 -: ARG_W];
                    work_d = work_q << ARG_W;
                    k_d    = k_q + KW'(1);
                    if (k_q == KW'(NUM_ARGS - 1)) begin
                        res_d       = RES_W'(acc_d);
                        res_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end
                end
            end
            S_OUT: begin
                if (f_res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_comb begin
        push     = f_req_valid & ready_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Flags are registered from the post-edge occupancy and state.
        ready_d = (count_d < CW'(DEPTH));
        busy_d  = (count_d != '0) | (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            work_q      <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= f_req_args;
        end
    end

    assign f_req_ready = ready_q;
    assign f_req_busy  = busy_q;
    assign f_req_count = count_q;
    assign f_res_valid = res_valid_q;
    assign f_res_0     = res_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ext_entry_queue.sv
// Bench for ext_entry_queue: four configurations share one stimulus stream and are
// compared every cycle against a queue-based timing model, plus literal spot checks.
module tb_ext_entry_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        res_ready = 1'b0;
    logic [63:0] req_args = '0;

    logic        rdy [4];
    logic        busy [4];
    logic        rv [4];
    logic [2:0]  cnt [4];
    logic [1:0]  st [4];
    logic [63:0] res [4];
    logic [63:0] res_a, res_b;
    logic [31:0] res_c, res_d;

    int cfg_aw [4] = '{32, 32, 8, 8};
    int cfg_na [4] = '{2, 2, 4, 4};
    int cfg_md [4] = '{0, 1, 0, 1};

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_q [$];

    always #5 clk = ~clk;

    ext_entry_queue #(.ARG_W(32), .NUM_ARGS(2), .DEPTH(4), .MODE(0)) u_a (
        .clk(clk), .rst(rst), .f_req_valid(valid), .f_req_ready(rdy[0]), .f_req_busy(busy[0]),
        .f_req_args(req_args), .f_req_count(cnt[0]), .f_res_valid(rv[0]), .f_res_ready(res_ready),
        .f_res_0(res_a), .dbg_state(st[0]));
    ext_entry_queue #(.ARG_W(32), .NUM_ARGS(2), .DEPTH(4), .MODE(1)) u_b (
        .clk(clk), .rst(rst), .f_req_valid(valid), .f_req_ready(rdy[1]), .f_req_busy(busy[1]),
        .f_req_args(req_args), .f_req_count(cnt[1]), .f_res_valid(rv[1]), .f_res_ready(res_ready),
        .f_res_0(res_b), .dbg_state(st[1]));
    ext_entry_queue #(.ARG_W(8), .NUM_ARGS(4), .DEPTH(4), .MODE(0)) u_c (
        .clk(clk), .rst(rst), .f_req_valid(valid), .f_req_ready(rdy[2]), .f_req_busy(busy[2]),
        .f_req_args(req_args[31:0]), .f_req_count(cnt[2]), .f_res_valid(rv[2]), .f_res_ready(res_ready),
        .f_res_0(res_c), .dbg_state(st[2]));
    ext_entry_queue #(.ARG_W(8), .NUM_ARGS(4), .DEPTH(4), .MODE(1)) u_d (
        .clk(clk), .rst(rst), .f_req_valid(valid), .f_req_ready(rdy[3]), .f_req_busy(busy[3]),
        .f_req_args(req_args[31:0]), .f_req_count(cnt[3]), .f_res_valid(rv[3]), .f_res_ready(res_ready),
        .f_res_0(res_d), .dbg_state(st[3]));

    assign res[0] = res_a;
    assign res[1] = res_b;
    assign res[2] = {32'h0, res_c};
    assign res[3] = {32'h0, res_d};

    task automatic check(string nm, int g, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %h expected %h", nm, g, act, exp);
        end
    endtask

    // Result of one call from its packed args; arg0 is the most significant slice.
    function automatic logic [63:0] exp_res(int g, logic [63:0] a);
        int aw = cfg_aw[g];
        int na = cfg_na[g];
        logic [63:0] amask = (64'd1 << aw) - 64'd1;
        logic [63:0] full = (aw * na == 64) ? '1 : ((64'd1 << (aw * na)) - 64'd1);
        logic [63:0] sum = '0;
        if (cfg_md[g] == 0) return a & full;
        for (int i = 0; i < na; i++) sum = sum + ((a >> (aw * (na - 1 - i))) & amask);
        return sum & amask;
    endfunction

    // Model: pending calls as expected results; stage 0 idle, 1 computing, 2 presenting.
    logic [63:0] exp_q [4][$];
    int          m_stage [4] = '{0, 0, 0, 0};
    int          m_cnt [4] = '{0, 0, 0, 0};
    logic [63:0] m_cur [4] = '{64'h0, 64'h0, 64'h0, 64'h0};
    logic [63:0] m_res [4] = '{64'h0, 64'h0, 64'h0, 64'h0};
    logic        m_ready [4] = '{1'b0, 1'b0, 1'b0, 1'b0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < 4; g++) begin
                exp_q[g].delete();
                m_stage[g] = 0;
                m_cnt[g] = 0;
                m_res[g] = '0;
                m_ready[g] = 1'b0;
            end
        end else begin
            for (int g = 0; g < 4; g++) begin
                bit acc, pop;
                acc = valid && m_ready[g];
                pop = (m_stage[g] == 0) && (exp_q[g].size() != 0);
                if (m_stage[g] == 2) begin
                    if (res_ready) m_stage[g] = 0;
                end else if (m_stage[g] == 1) begin
                    m_cnt[g]--;
                    if (m_cnt[g] == 0) begin
                        m_stage[g] = 2;
                        m_res[g] = m_cur[g];
                    end
                end
                if (pop) begin
                    m_cur[g] = exp_q[g].pop_front();
                    m_stage[g] = 1;
                    m_cnt[g] = (cfg_md[g] == 0) ? 1 : cfg_na[g];
                end
                if (acc) exp_q[g].push_back(exp_res(g, req_args));
                m_ready[g] = exp_q[g].size() < 4;
            end
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            check("ready", g, 64'(rdy[g]), 64'(m_ready[g]));
            check("busy", g, 64'(busy[g]), 64'((exp_q[g].size() != 0) || (m_stage[g] != 0)));
            check("count", g, 64'(cnt[g]), 64'(exp_q[g].size()));
            check("res_valid", g, 64'(rv[g]), 64'(m_stage[g] == 2));
            check("res", g, res[g], m_res[g]);
        end
    end

    always @(posedge clk) begin
        if (!rst && rv[0] && res_ready) hs_q.push_back(cyc);
        cyc++;
    end

    task automatic drain();
        int n = 0;
        valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        while ((busy[0] | busy[1] | busy[2] | busy[3]) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 0, 64'(n < 300), 64'd1);
        res_ready = 1'b0;
    endtask

    task automatic one_call(logic [63:0] a, int g, int lat, logic [63:0] lit);
        valid = 1'b1;
        req_args = a;
        res_ready = 1'b0;
        @(negedge clk);
        valid = 1'b0;
        check("busy_after_accept", g, 64'(busy[g]), 64'd1);
        for (int e = 1; e <= lat; e++) begin
            @(negedge clk);
            check("latency_valid", g, 64'(rv[g]), 64'(e == lat));
            check("busy_hold", g, 64'(busy[g]), 64'd1);
        end
        check("result_literal", g, res[g], lit);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("valid_drop", g, 64'(rv[g]), 64'd0);
        check("busy_drop", g, 64'(busy[g]), 64'd0);
    endtask

    // Presents one call to instance 0 and returns after the edge that accepts it.
    task automatic send_a(logic [63:0] a);
        int n = 0;
        valid = 1'b1;
        req_args = a;
        while (!rdy[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 0, 64'(n < 50), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int base;
        int mx;
        repeat (3) @(negedge clk);
        check("reset_ready", 0, 64'(rdy[0]), 64'd0);
        check("reset_busy", 0, 64'(busy[0]), 64'd0);
        check("reset_count", 0, 64'(cnt[0]), 64'd0);
        check("reset_res", 0, res[0], 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 0, 64'(rdy[0]), 64'd1);

        one_call(64'h00000001_00000002, 0, 2, 64'h0000000100000002);
        drain();
        one_call(64'hFFFFFFFF_00000002, 1, 3, 64'h1);
        drain();
        one_call(64'h00000000_11223344, 2, 2, 64'h11223344);
        drain();
        one_call(64'h00000000_11223344, 3, 5, 64'hAA);
        drain();

        // Back-pressure: results held off until the FIFO of instance 0 fills.
        hs_q.delete();
        res_ready = 1'b0;
        for (int n = 0; n < 5; n++) send_a({32'(n), 32'(n + 1)});
        check("bp_count_full", 0, 64'(cnt[0]), 64'd4);
        check("bp_ready_low", 0, 64'(rdy[0]), 64'd0);
        valid = 1'b1;
        req_args = {32'd5, 32'd6};
        repeat (3) begin
            @(negedge clk);
            check("bp_stall_ready", 0, 64'(rdy[0]), 64'd0);
            check("bp_stall_count", 0, 64'(cnt[0]), 64'd4);
        end
        res_ready = 1'b1;
        send_a({32'd5, 32'd6});
        drain();
        check("bp_results", 0, 64'(hs_q.size()), 64'd6);
        check("bp_count_empty", 0, 64'(cnt[0]), 64'd0);

        // Streaming: one new call each time a result is taken.
        hs_q.delete();
        mx = 0;
        res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1;
            req_args = {$urandom, $urandom};
            for (int j = 0; j < 3; j++) begin
                @(negedge clk);
                valid = 1'b0;
                if (int'(cnt[0]) > mx) mx = int'(cnt[0]);
            end
        end
        drain();
        check("stream_count_max", 0, 64'(mx <= 1), 64'd1);
        check("stream_results", 0, 64'(hs_q.size()), 64'd8);
        for (int i = 1; i < hs_q.size(); i++)
            check("stream_interval", 0, 64'(hs_q[i] - hs_q[i-1]), 64'd3);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            valid = ($urandom_range(0, 99) < 60);
            res_ready = $urandom_range(0, 1) == 1;
            req_args = {$urandom, $urandom};
            @(negedge clk);
        end
        drain();

        // Asynchronous reset while the sum instance is mid-computation.
        res_ready = 1'b0;
        valid = 1'b1;
        req_args = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        valid = 1'b0;
        check("rst_pre_calc", 1, 64'(st[1]), 64'd1);
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) begin
            check("rst_async_valid", g, 64'(rv[g]), 64'd0);
            check("rst_async_busy", g, 64'(busy[g]), 64'd0);
            check("rst_async_count", g, 64'(cnt[g]), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_back", 0, 64'(rdy[0]), 64'd1);
        one_call(64'h00000005_00000006, 0, 2, 64'h0000000500000006);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
